// File: rtl/data_memory_stage.sv
// rtl/data_memory_stage.sv - MIPS stage-3 data memory access with registered writeback value
module data_memory_stage #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  stage,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    output logic [31:0] mem_read_data,
    output logic [31:0] writeback_data,
    output logic        mem_done,
    output logic        addr_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   ram [DEPTH_WORDS];
    logic [29:0]   word_idx;
    logic [AW-1:0] ram_addr;
    logic          aligned;
    logic          in_range;
    logic          addr_valid;
    logic          active;
    logic [31:0]   old_word;

    // Address decode: range check uses the full word index so high addresses never alias low words
    always_comb begin
        word_idx   = alu_result[31:2];
        ram_addr   = word_idx[AW-1:0];
        aligned    = (alu_result[1:0] == 2'b00);
        in_range   = (word_idx < 30'(DEPTH_WORDS));
        addr_valid = aligned & in_range;
        active     = (stage == 3'd3);
        old_word   = addr_valid ? ram[ram_addr] : 32'd0;
    end

    // Stage-3 access: RAM write, read-before-write load, writeback select, sticky fault, done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                ram[i] <= 32'd0;
            end
            mem_read_data  <= 32'd0;
            writeback_data <= 32'd0;
            mem_done       <= 1'b0;
            addr_fault     <= 1'b0;
        end else if (active) begin
            if (mem_write && addr_valid) begin
                ram[ram_addr] <= write_data;
            end
            if (mem_read) begin
                mem_read_data <= old_word;
            end
            writeback_data <= mem_to_reg ? old_word : alu_result;
            if ((mem_read || mem_write) && !addr_valid) begin
                addr_fault <= 1'b1;
            end
            mem_done <= 1'b1;
        end else begin
            mem_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_memory_stage.sv
// tb/tb_data_memory_stage.sv - scoreboard bench for data_memory_stage
module tb_data_memory_stage;

    logic        clock;
    logic        reset;
    logic [2:0]  stage;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [31:0] mem_read_data;
    logic [31:0] writeback_data;
    logic        mem_done;
    logic        addr_fault;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] wb;
        logic        f;
        string       name;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int pushed = 0;
    int popped = 0;

    data_memory_stage #(.DEPTH_WORDS(256)) dut (
        .clock(clock),
        .reset(reset),
        .stage(stage),
        .alu_result(alu_result),
        .write_data(write_data),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_to_reg(mem_to_reg),
        .mem_read_data(mem_read_data),
        .writeback_data(writeback_data),
        .mem_done(mem_done),
        .addr_fault(addr_fault)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One stage-3 access followed by an idle stage, expected response queued for the monitor
    task automatic access(input string name, input logic rd, input logic wr, input logic m2r,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic [31:0] exp_wb, input logic exp_f);
        exp_t e;
        @(negedge clock);
        stage      = 3'd3;
        mem_read   = rd;
        mem_write  = wr;
        mem_to_reg = m2r;
        alu_result = addr;
        write_data = wdata;
        e.rd = exp_rd; e.wb = exp_wb; e.f = exp_f; e.name = name;
        q.push_back(e);
        pushed++;
        @(negedge clock);
        stage     = 3'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Monitor: compare every mem_done pulse against the scoreboard and flag back-to-back pulses
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (mem_done === 1'b1) begin
                chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: actual=pulse required=none");
                end else begin
                    e = q.pop_front();
                    popped++;
                    chk({e.name, ".mem_read_data"}, mem_read_data, e.rd);
                    chk({e.name, ".writeback_data"}, writeback_data, e.wb);
                    chk({e.name, ".addr_fault"}, {31'd0, addr_fault}, {31'd0, e.f});
                end
            end
            prev_done = (mem_done === 1'b1);
        end
    end

    initial begin
        reset = 1'b1; stage = 3'd0; alu_result = 32'd0; write_data = 32'd0;
        mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset.mem_read_data", mem_read_data, 32'd0);
        chk("reset.writeback_data", writeback_data, 32'd0);
        chk("reset.mem_done", {31'd0, mem_done}, 32'd0);
        chk("reset.addr_fault", {31'd0, addr_fault}, 32'd0);
        reset = 1'b0;

        access("lw_after_reset", 1, 0, 1, 32'h40, 0, 32'h0, 32'h0, 0);
        access("lw_top_word", 1, 0, 1, 32'h3FC, 0, 32'h0, 32'h0, 0);
        access("sw_10", 0, 1, 0, 32'h10, 32'hDEADBEEF, 32'h0, 32'h10, 0);
        access("lw_10", 1, 0, 1, 32'h10, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        access("rtype", 0, 0, 0, 32'h1234, 32'h5555, 32'hDEADBEEF, 32'h1234, 0);
        access("lw_10_after_rtype", 1, 0, 1, 32'h10, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);

        @(negedge clock);
        stage = 3'd2; mem_write = 1'b1; alu_result = 32'h10; write_data = 32'h55;
        @(negedge clock);
        chk("gated.mem_done", {31'd0, mem_done}, 32'd0);
        stage = 3'd0; mem_write = 1'b0;
        access("lw_10_after_gated", 1, 0, 1, 32'h10, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);

        access("sw_top_word", 0, 1, 0, 32'h3FC, 32'h77, 32'hDEADBEEF, 32'h3FC, 0);
        access("lw_top_word2", 1, 0, 1, 32'h3FC, 0, 32'h77, 32'h77, 0);
        access("sw_14", 0, 1, 0, 32'h14, 32'hA, 32'h77, 32'h14, 0);
        access("rbw_14", 1, 1, 1, 32'h14, 32'hB, 32'hA, 32'hA, 0);
        access("lw_14", 1, 0, 1, 32'h14, 0, 32'hB, 32'hB, 0);

        access("sw_misaligned", 0, 1, 0, 32'h13, 32'h99, 32'hB, 32'h13, 1);
        access("lw_10_after_misaligned", 1, 0, 1, 32'h10, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1);
        access("lw_misaligned", 1, 0, 1, 32'h13, 0, 32'h0, 32'h0, 1);
        access("sw_out_of_range", 0, 1, 0, 32'h400, 32'h66, 32'h0, 32'h400, 1);
        access("sw_far_high", 0, 1, 0, 32'h80000000, 32'h67, 32'h0, 32'h80000000, 1);
        access("lw_0_no_wrap", 1, 0, 1, 32'h0, 0, 32'h0, 32'h0, 1);
        access("lw_out_of_range", 1, 0, 0, 32'h400, 0, 32'h0, 32'h400, 1);
        access("rtype_fault_sticky", 0, 0, 0, 32'h8, 0, 32'h0, 32'h8, 1);

        @(negedge clock);
        reset = 1'b1; stage = 3'd3; mem_write = 1'b1; alu_result = 32'h20; write_data = 32'h12345678;
        @(negedge clock);
        chk("reset_midop.mem_done", {31'd0, mem_done}, 32'd0);
        chk("reset_midop.addr_fault", {31'd0, addr_fault}, 32'd0);
        chk("reset_midop.writeback_data", writeback_data, 32'd0);
        reset = 1'b0; stage = 3'd0; mem_write = 1'b0;
        access("lw_20_after_reset", 1, 0, 1, 32'h20, 0, 32'h0, 32'h0, 0);
        access("lw_10_cleared", 1, 0, 1, 32'h10, 0, 32'h0, 32'h0, 0);

        repeat (3) @(negedge clock);
        @(posedge clock);
        #1;
        chk("scoreboard_drained", popped, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
